mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the instruction-fetch requester and the load/store requester.
- Sits between the PC/fetch logic and the data path on one side and a single memory on the other. This is the step from a direct instruction feed to a shared code/data memory.
- Allows one outstanding transaction at a time.
- Data has fixed priority, with a starvation limit that guarantees fetch forward progress.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/arb_priority_starve.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified code/data memory port arbiter.
// Imported by the arbiter top and its priority/starvation sub-block.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    REQ_IF,
    REQ_D
  } requester_t;

  localparam int DEF_MEM_LAT    = 1;
  localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/arb_priority_starve.sv
// Fixed data-over-fetch priority with a starvation limit for fetch.
// Holds the count of consecutive data grants taken while fetch waits.
module arb_priority_starve
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic if_req,
  input  logic d_req,
  output logic gnt_if,
  output logic gnt_d
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  if (STARVE_MAX < 1) begin : g_bad_starve
    $error("STARVE_MAX must be >= 1");
  end

  logic [CW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt == CW'(STARVE_MAX));

  // Data wins unless fetch has been passed over STARVE_MAX times in a row.
  always_comb begin
    gnt_if = 1'b0;
    gnt_d  = 1'b0;
    if (arb_en) begin
      if (d_req && !(if_req && starved)) begin
        gnt_d = 1'b1;
      end else if (if_req) begin
        gnt_if = 1'b1;
      end
    end
  end

  // Count data grants that overtake a waiting fetch, saturating at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!if_req || gnt_if) begin
      starve_cnt <= '0;
    end else if (gnt_d && !starved) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and load/store requesters.
// One outstanding transaction; fixed data priority with fetch anti-starvation.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  if (MEM_LAT < 1) begin : g_bad_lat
    $error("MEM_LAT must be >= 1");
  end

  arb_state_t        state;
  arb_state_t        state_nx;
  logic [LW-1:0]     lat_cnt;
  logic [LW-1:0]     lat_nx;
  requester_t        owner;
  logic              owner_we;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              busy_q;
  logic              arb_en;
  logic              gnt_if;
  logic              gnt_d;
  logic              grant;
  logic              cap;
  logic              resp;

  assign arb_en = !rst && (state != WAIT);
  assign grant  = gnt_if | gnt_d;
  assign cap    = (state == WAIT) && (lat_cnt == '0);
  assign resp   = !rst && (state == RESP);

  arb_priority_starve #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio (
    .clk   (clk),
    .rst   (rst),
    .arb_en(arb_en),
    .if_req(if_req),
    .d_req (d_req),
    .gnt_if(gnt_if),
    .gnt_d (gnt_d)
  );

  // Next state: grant from IDLE/RESP, count out the memory latency in WAIT.
  always_comb begin
    state_nx = state;
    lat_nx   = lat_cnt;
    unique case (state)
      IDLE, RESP: begin
        if (grant) begin
          state_nx = WAIT;
          lat_nx   = LW'(MEM_LAT - 1);
        end else begin
          state_nx = IDLE;
        end
      end
      WAIT: begin
        if (cap) begin
          state_nx = RESP;
        end else begin
          lat_nx = lat_cnt - LW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, latency counter, busy flag and the owner of the open transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      busy_q   <= 1'b0;
      owner    <= REQ_IF;
      owner_we <= 1'b0;
    end else begin
      state   <= state_nx;
      lat_cnt <= lat_nx;
      busy_q  <= (state_nx != IDLE);
      if (grant) begin
        owner    <= gnt_d ? REQ_D : REQ_IF;
        owner_we <= gnt_d & d_we;
      end
    end
  end

  // Capture read data for the owner; a store completes with zero data.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else if (cap) begin
      if (owner == REQ_D) begin
        d_rdata_q <= owner_we ? '0 : mem_rdata;
      end else begin
        if_rdata_q <= mem_rdata;
      end
    end
  end

  // Steer the winner's request fields onto the memory port.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    unique case (1'b1)
      gnt_d: begin
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_wstrb = d_wstrb;
      end
      gnt_if: begin
        mem_addr = if_addr;
      end
      default: ;
    endcase
  end

  assign if_gnt    = gnt_if;
  assign d_gnt     = gnt_d;
  assign mem_req   = grant;
  assign if_rvalid = resp && (owner == REQ_IF);
  assign d_rvalid  = resp && (owner == REQ_D);
  assign if_rdata  = rst ? '0 : if_rdata_q;
  assign d_rdata   = rst ? '0 : d_rdata_q;
  assign busy      = busy_q && !rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a
// transaction-timing reference model with a behavioural memory.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int LAT  = 2;
  localparam int SMAX = DEF_STARVE_MAX;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [SW-1:0] d_wstrb;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
  } dreq_t;

  logic [AW-1:0] if_q[$];
  dreq_t         d_q[$];
  logic [DW-1:0] mem [0:127];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int rate = 100;
  int rst_from = 0;
  int rst_to = 2;

  int            next_ok = 0;
  int            gnt_cyc = 0;
  int            resp_cyc = -1;
  bit            gnt_valid = 0;
  bit            resp_pend = 0;
  bit            resp_d = 0;
  logic [DW-1:0] resp_data = '0;
  logic [DW-1:0] hold_i = '0;
  logic [DW-1:0] hold_d = '0;
  int            starve = 0;
  int            rd_cyc = -1;
  logic [DW-1:0] rd_word = '0;
  bit            saw_gi = 0;
  bit            saw_gd = 0;

  int            g_cyc[$];
  bit            g_d[$];
  int            r_cyc[$];
  bit            r_d[$];
  logic [DW-1:0] r_dat[$];

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    logic [6:0] w;
    w = 7'($urandom_range(0, 127));
    return {23'd0, w, 2'b00};
  endfunction

  task automatic drive();
    dreq_t r;
    rst = (cyc >= rst_from) && (cyc <= rst_to);
    if (saw_gi) if_req = 1'b0;
    if (saw_gd) d_req = 1'b0;
    if (!if_req && if_q.size() > 0 &&
        int'($urandom_range(0, 99)) < rate) begin
      if_req  = 1'b1;
      if_addr = if_q.pop_front();
    end
    if (!d_req && d_q.size() > 0 &&
        int'($urandom_range(0, 99)) < rate) begin
      r       = d_q.pop_front();
      d_req   = 1'b1;
      d_we    = r.we;
      d_addr  = r.addr;
      d_wdata = r.wdata;
      d_wstrb = r.strb;
    end
    if (!if_req) if_addr = $urandom();
    if (!d_req) begin
      d_we    = 1'($urandom());
      d_addr  = $urandom();
      d_wdata = $urandom();
      d_wstrb = SW'($urandom());
    end
    mem_rdata = (cyc == rd_cyc) ? rd_word : $urandom();
  endtask

  task automatic step();
    bit            gi;
    bit            gd;
    bit            rvi;
    bit            rvd;
    bit            bsy;
    logic [AW-1:0] a;
    gi = 0;
    gd = 0;
    if (!rst && cyc >= next_ok) begin
      if (d_req && !(if_req && starve == SMAX)) gd = 1;
      else if (if_req) gi = 1;
    end
    rvi = !rst && resp_pend && cyc == resp_cyc && !resp_d;
    rvd = !rst && resp_pend && cyc == resp_cyc && resp_d;
    if (rvi) hold_i = resp_data;
    if (rvd) hold_d = resp_data;
    bsy = !rst && gnt_valid && cyc > gnt_cyc && cyc <= gnt_cyc + LAT + 1;

    check("if_gnt", if_gnt, gi);
    check("d_gnt", d_gnt, gd);
    check("mem_req", mem_req, gi | gd);
    check("if_rvalid", if_rvalid, rvi);
    check("d_rvalid", d_rvalid, rvd);
    check("busy", busy, bsy);
    check("if_rdata", if_rdata, rst ? '0 : hold_i);
    check("d_rdata", d_rdata, rst ? '0 : hold_d);
    if (gd)
      check("mem_d", {mem_we, mem_addr, mem_wdata, mem_wstrb},
            {d_we, d_addr, d_wdata, d_wstrb});
    if (gi)
      check("mem_if", {mem_we, mem_addr, mem_wstrb},
            {1'b0, if_addr, 4'h0});
    if (rst)
      check("rst_mem", {mem_we, mem_addr, mem_wdata, mem_wstrb}, '0);

    if (if_gnt || d_gnt) begin
      g_cyc.push_back(cyc);
      g_d.push_back(d_gnt);
    end
    if (if_rvalid) begin
      r_cyc.push_back(cyc);
      r_d.push_back(1'b0);
      r_dat.push_back(if_rdata);
    end
    if (d_rvalid) begin
      r_cyc.push_back(cyc);
      r_d.push_back(1'b1);
      r_dat.push_back(d_rdata);
    end
    saw_gi = if_gnt;
    saw_gd = d_gnt;

    if (rst) begin
      next_ok   = cyc + 1;
      starve    = 0;
      resp_pend = 0;
      gnt_valid = 0;
      hold_i    = '0;
      hold_d    = '0;
    end else begin
      if (gi || gd) begin
        a         = gd ? d_addr : if_addr;
        next_ok   = cyc + LAT + 1;
        gnt_valid = 1;
        gnt_cyc   = cyc;
        resp_pend = 1;
        resp_cyc  = cyc + LAT + 1;
        resp_d    = gd;
        resp_data = (gd && d_we) ? '0 : mem[a[8:2]];
        rd_cyc    = cyc + LAT;
        rd_word   = mem[a[8:2]];
        if (gd && d_we)
          for (int b = 0; b < SW; b++)
            if (d_wstrb[b]) mem[a[8:2]][8*b +: 8] = d_wdata[8*b +: 8];
      end
      if (!if_req || gi) starve = 0;
      else if (gd && starve < SMAX) starve++;
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      drive();
      @(negedge clk);
      step();
      cyc++;
    end
  endtask

  task automatic drain(input string tag, input int limit);
    int k;
    k = 0;
    while ((if_q.size() > 0 || d_q.size() > 0 || if_req || d_req ||
            cyc <= next_ok) && k < limit) begin
      run(1);
      k++;
    end
    check({tag, "_drain"}, k < limit, 1'b1);
  endtask

  task automatic clear_logs();
    g_cyc.delete();
    g_d.delete();
    r_cyc.delete();
    r_d.delete();
    r_dat.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int            t0;
    logic [DW-1:0] w0;
    logic [DW-1:0] w1;
    logic [DW-1:0] w2;
    bit            pat[10];
    dreq_t         r;

    rst     = 1'b1;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    d_wstrb = '0;
    mem_rdata = '0;
    for (int i = 0; i < 128; i++) mem[i] = $urandom();
    run(4);

    // single fetch
    clear_logs();
    mem[4] = 32'h0000_2083;
    if_q.push_back(32'h0000_0010);
    t0 = cyc;
    drain("fetch", 50);
    check("t1_ngnt", g_cyc.size(), 1);
    check("t1_gcyc", g_cyc[0], t0);
    check("t1_who", g_d[0], 1'b0);
    check("t1_rcyc", r_cyc[0], t0 + LAT + 1);
    check("t1_rdat", r_dat[0], 32'h0000_2083);

    // load and fetch together
    clear_logs();
    w0 = mem[64];
    r = '{we: 1'b0, addr: 32'h100, wdata: '0, strb: '0};
    d_q.push_back(r);
    if_q.push_back(32'h0000_0020);
    t0 = cyc;
    drain("ldif", 50);
    check("t2_first_d", g_d[0], 1'b1);
    check("t2_gcyc", g_cyc[0], t0);
    check("t2_second_if", g_d[1], 1'b0);
    check("t2_gap", g_cyc[1] - g_cyc[0], LAT + 1);
    check("t2_r_who", r_d[0], 1'b1);
    check("t2_r_dat", r_dat[0], w0);

    // store
    clear_logs();
    r = '{we: 1'b1, addr: 32'h104, wdata: 32'hDEAD_BEEF, strb: 4'hF};
    d_q.push_back(r);
    drain("store", 50);
    check("t3_nresp", r_cyc.size(), 1);
    check("t3_r_who", r_d[0], 1'b1);
    check("t3_r_dat", r_dat[0], 0);

    // starvation limit
    clear_logs();
    for (int i = 0; i < 10; i++) begin
      r = '{we: 1'b0, addr: rnd_addr(), wdata: '0, strb: '0};
      d_q.push_back(r);
    end
    for (int i = 0; i < 14; i++) if_q.push_back(rnd_addr());
    drain("starve", 200);
    pat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    for (int i = 0; i < 10; i++)
      check($sformatf("t4_g%0d", i), g_d[i], pat[i]);

    // reset in the second WAIT cycle of a fetch
    clear_logs();
    w1 = mem[13];
    if_q.push_back(32'h30);
    if_q.push_back(32'h34);
    t0 = cyc;
    rst_from = t0 + 2;
    rst_to = t0 + 2;
    drain("rst", 50);
    check("t5_ngnt", g_cyc.size(), 2);
    check("t5_g2cyc", g_cyc[1], t0 + 3);
    check("t5_nresp", r_cyc.size(), 1);
    check("t5_rcyc", r_cyc[0], t0 + 3 + LAT + 1);
    check("t5_rdat", r_dat[0], w1);

    // back-to-back fetches
    clear_logs();
    w0 = mem[0];
    w1 = mem[1];
    w2 = mem[2];
    if_q.push_back(32'h0);
    if_q.push_back(32'h4);
    if_q.push_back(32'h8);
    drain("b2b", 50);
    check("t6_g01", g_cyc[1] - g_cyc[0], LAT + 1);
    check("t6_g12", g_cyc[2] - g_cyc[1], LAT + 1);
    check("t6_r01", r_cyc[1] - r_cyc[0], LAT + 1);
    check("t6_r12", r_cyc[2] - r_cyc[1], LAT + 1);
    check("t6_d0", r_dat[0], w0);
    check("t6_d1", r_dat[1], w1);
    check("t6_d2", r_dat[2], w2);

    // random traffic with a reset pulse in the middle
    rate = 50;
    for (int i = 0; i < 150; i++) begin
      r.we    = 1'($urandom());
      r.addr  = rnd_addr();
      r.wdata = $urandom();
      r.strb  = SW'($urandom());
      d_q.push_back(r);
      if_q.push_back(rnd_addr());
    end
    rst_from = cyc + 200;
    rst_to = cyc + 201;
    drain("rand", 5000);
    run(5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
